alarm_ctrl: RTL
===============

# alarm_ctrl

Alarm sequencing controller for the clock design. Compares the running BCD time against the BCD alarm setting held by the alarm-set block, then sequences ringing, snooze and auto-off. It drives the buzzer and status indicators. Single clock domain; all time, alarm and tick inputs come from the same clock.

## Interface
- RING_SECS, default 60: ticks the alarm rings before auto-off.
- SNOOZE_SECS, default 300: ticks spent in snooze before re-ringing.
- MAX_SNOOZE, default 3: snoozes allowed per alarm event.
- CNT_W, default 9: seconds-counter width; must hold max(RING_SECS, SNOOZE_SECS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle strobe, once per second.
- th1, th0, tm1, tm0, ts1, ts0  in  4 each  current time, BCD (hours, minutes, seconds).
- ah1, ah0, am1, am0  in  4 each  alarm setting, BCD.
- alarm_en  in  1  alarm switch, level, 1 = armed.
- snooze_n  in  1  snooze pushbutton, active-low, asynchronous.
- stop_n  in  1  stop pushbutton, active-low, asynchronous.
- buzzer  out  1  buzzer drive, registered.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- missed  out  1  sticky: last event auto-timed-out.
- snooze_cnt  out  2  snoozes used in the current event.

## Operation
- Button front end:
  - Each button passes through a 2-FF synchronizer, reset to 1.
  - A falling edge of the synchronized level gives a one-cycle press pulse.
- match = alarm_en & (th1,th0,tm1,tm0 == ah1,ah0,am1,am0) & ts1==0 & ts0==0.
- FSM states: IDLE, RING, SNOOZE, DONE.
- IDLE:
  - On a tick_1hz cycle with match: go to RING, load ring counter = RING_SECS, snooze_cnt = 0, clear missed.
- RING:
  - Each tick decrements the ring counter. Beep phase toggles each tick; buzzer = phase, with phase = 1 on RING entry.
  - stop press -> DONE.
  - snooze press with snooze_cnt < MAX_SNOOZE -> SNOOZE: load snooze counter = SNOOZE_SECS, snooze_cnt += 1.
  - snooze press with snooze_cnt == MAX_SNOOZE is ignored.
  - Tick while the ring counter == 1 -> DONE and set missed.
- SNOOZE:
  - Each tick decrements the snooze counter.
  - Tick while the counter == 1 -> RING, reload ring counter, phase = 1.
  - stop press -> DONE. snooze press is ignored.
- DONE:
  - Buzzer off.
  - Return to IDLE on the first clock where the hour/minute compare is false. This blocks re-trigger within the same minute.
- alarm_en = 0 in any state -> IDLE on the next clock; buzzer off. missed and snooze_cnt are held.
- Same-cycle priority: alarm_en low > stop > snooze > tick.
- missed clears only on the next IDLE->RING trigger or on reset.
- Counters decrement only on tick cycles, never below 0. Compares are on raw 4-bit BCD fields; invalid BCD simply never matches.

## Timing
- Reset asserted: state IDLE; buzzer, ringing, snoozing, missed = 0; snooze_cnt = 0; counters 0; phase 0; synchronizer flops 1. Takes effect immediately and asynchronously, including mid-ring.
- Trigger: match on tick cycle N -> ringing = 1 and buzzer = 1 in cycle N+1.
- Button latency: pin falls at cycle N -> press pulse at N+2 -> state and outputs change at N+3. A held button gives exactly one press.
- Ring duration: exactly RING_SECS ticks from entry. Snooze duration: exactly SNOOZE_SECS ticks.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for the bench: RING_SECS=4, SNOOZE_SECS=6, MAX_SNOOZE=2.
- Trigger: alarm 07:30, time stepped to 07:30:00 with a tick -> ringing=1 next cycle; buzzer 1,0,1,0 on successive ticks; after 4 ticks ringing=0, missed=1, state DONE until the minute reaches 07:31, then IDLE.
- Stop: ring, press stop_n after 2 ticks -> ringing=0 three cycles after the pin falls; missed=0; no re-trigger at 07:30:01–07:30:59.
- Snooze: two snooze presses, each followed by 6 ticks -> RING re-entered each time, snooze_cnt=1 then 2; a third snooze press is ignored, ringing stays 1.
- Priority: snooze and stop fall on the same cycle -> DONE, snooze_cnt unchanged; stop press on the same cycle as the final ring tick -> DONE, missed=0.
- Disable: alarm_en cleared mid-RING -> IDLE next cycle, buzzer=0; re-armed at 07:30:20 -> no ring until next 07:30:00 match.
- Reset: reset pulsed low during SNOOZE -> all outputs 0 immediately; a later match rings normally with snooze_cnt=0.

Source files
------------

// File: rtl/alarm_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alarm_ctrl
//
// Alarm sequencing controller. Compares the running BCD time against the BCD
// alarm setting and sequences ringing, snooze and auto-off, driving the buzzer
// and status indicators. Single clock domain.
//
// Parameters:
//   RING_SECS    ticks the alarm rings before auto-off
//   SNOOZE_SECS  ticks spent in snooze before re-ringing
//   MAX_SNOOZE   snoozes allowed per alarm event (fits in 2 bits)
//   CNT_W        seconds-counter width, holds max(RING_SECS, SNOOZE_SECS)
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   tick_1hz    one-cycle strobe, once per second
//   th1..ts0    current time, BCD hh:mm:ss
//   ah1..am0    alarm setting, BCD hh:mm
//   alarm_en    alarm switch, 1 = armed
//   snooze_n    snooze pushbutton, active-low, asynchronous
//   stop_n      stop pushbutton, active-low, asynchronous
//   buzzer      buzzer drive (registered)
//   ringing     high while ringing (registered)
//   snoozing    high while snoozing (registered)
//   missed      sticky: last event ended by auto-off
//   snooze_cnt  snoozes used in the current event
// -----------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] th1,
    input  logic [3:0] th0,
    input  logic [3:0] tm1,
    input  logic [3:0] tm0,
    input  logic [3:0] ts1,
    input  logic [3:0] ts0,
    input  logic [3:0] ah1,
    input  logic [3:0] ah0,
    input  logic [3:0] am1,
    input  logic [3:0] am0,
    input  logic       alarm_en,
    input  logic       snooze_n,
    input  logic       stop_n,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic       missed,
    output logic [1:0] snooze_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RING_LOAD    = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD  = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    // Saturating decrement: counters never wrap below zero.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    logic snz_sync_p0, snz_sync_p1, snz_sync_p2;
    logic stp_sync_p0, stp_sync_p1, stp_sync_p2;
    logic snooze_press, stop_press;
    logic hm_match, match;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] ring_cnt, ring_cnt_nxt;
    logic [CNT_W-1:0] snz_cnt, snz_cnt_nxt;
    logic             phase, phase_nxt;
    logic             missed_nxt;
    logic [1:0]       snooze_cnt_nxt;

    // ---- stage p0/p1: button synchronizers, p2: edge-detect history ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snz_sync_p0 <= 1'b1;
            snz_sync_p1 <= 1'b1;
            snz_sync_p2 <= 1'b1;
            stp_sync_p0 <= 1'b1;
            stp_sync_p1 <= 1'b1;
            stp_sync_p2 <= 1'b1;
        end else begin
            snz_sync_p0 <= snooze_n;
            snz_sync_p1 <= snz_sync_p0;
            snz_sync_p2 <= snz_sync_p1;
            stp_sync_p0 <= stop_n;
            stp_sync_p1 <= stp_sync_p0;
            stp_sync_p2 <= stp_sync_p1;
        end
    end

    // Falling edge of the synchronized level; a held button yields one pulse.
    assign snooze_press = snz_sync_p2 & ~snz_sync_p1;
    assign stop_press   = stp_sync_p2 & ~stp_sync_p1;

    // Raw BCD field compares; invalid BCD simply never matches.
    assign hm_match = (th1 == ah1) && (th0 == ah0) && (tm1 == am1) && (tm0 == am0);
    assign match    = alarm_en && hm_match && (ts1 == 4'd0) && (ts0 == 4'd0);

    // ---- next-state logic; priority: alarm_en low > stop > snooze > tick ----
    always_comb begin
        state_nxt      = state;
        ring_cnt_nxt   = ring_cnt;
        snz_cnt_nxt    = snz_cnt;
        phase_nxt      = phase;
        missed_nxt     = missed;
        snooze_cnt_nxt = snooze_cnt;

        if (!alarm_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_1hz && match) begin
                        state_nxt      = RING;
                        ring_cnt_nxt   = RING_LOAD;
                        phase_nxt      = 1'b1;
                        snooze_cnt_nxt = 2'd0;
                        missed_nxt     = 1'b0;
                    end
                end
                RING: begin
                    if (stop_press) begin
                        state_nxt = DONE;
                    end else if (snooze_press && (snooze_cnt < SNOOZE_LIMIT)) begin
                        state_nxt      = SNOOZE;
                        snz_cnt_nxt    = SNOOZE_LOAD;
                        snooze_cnt_nxt = snooze_cnt + 2'd1;
                    end else if (tick_1hz) begin
                        // Last ring second: auto-off and flag the event as missed.
                        if (ring_cnt <= CNT_ONE) begin
                            state_nxt    = DONE;
                            missed_nxt   = 1'b1;
                            ring_cnt_nxt = '0;
                        end else begin
                            ring_cnt_nxt = dec_sat(ring_cnt);
                            phase_nxt    = ~phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_press) begin
                        state_nxt = DONE;
                    end else if (tick_1hz) begin
                        if (snz_cnt <= CNT_ONE) begin
                            state_nxt    = RING;
                            snz_cnt_nxt  = '0;
                            ring_cnt_nxt = RING_LOAD;
                            phase_nxt    = 1'b1;
                        end else begin
                            snz_cnt_nxt = dec_sat(snz_cnt);
                        end
                    end
                end
                DONE: begin
                    // Hold off until the minute moves on so the same minute
                    // cannot re-trigger the alarm.
                    if (!hm_match) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ---- stage p0: state, counters and registered outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            phase      <= 1'b0;
            missed     <= 1'b0;
            snooze_cnt <= 2'd0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring_cnt   <= ring_cnt_nxt;
            snz_cnt    <= snz_cnt_nxt;
            phase      <= phase_nxt;
            missed     <= missed_nxt;
            snooze_cnt <= snooze_cnt_nxt;
            ringing    <= (state_nxt == RING);
            snoozing   <= (state_nxt == SNOOZE);
            buzzer     <= (state_nxt == RING) && phase_nxt;
        end
    end

endmodule
